// File: rtl/mix_pkg.sv
// mix_pkg: shared definitions for the frame mixer.
//   - frame geometry defaults (pixel count, address width)
//   - pixel payload types (flat 24-bit word and its RGB view)
//   - controller state encoding
package mix_pkg;

    localparam int unsigned MIX_PIX_NUM = 16384;  // 128x128 frame
    localparam int unsigned MIX_ADDR_W  = 14;
    localparam int unsigned PIX_W       = 24;
    localparam int unsigned CH_W        = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mix_ctrl_if.sv
// mix_ctrl_if: control, source-read and result-write signals of the mixer.
//   master : the mix_ctrl side (drives strobes, addresses, result data)
//   slave  : the environment side (start, source pixels, write ready)
//   start    - request one frame mix
//   busy     - controller not idle
//   done     - one-cycle end-of-frame pulse
//   rd_en    - read strobe to both source memories
//   rd_addr  - shared source pixel address
//   pix1_in  - source-1 pixel, valid the cycle after rd_en
//   pix2_in  - source-2 pixel, valid the cycle after rd_en
//   wr_en    - result write request
//   wr_addr  - result address
//   wr_data  - mixed pixel
//   wr_ready - result memory accepts the write this cycle
interface mix_ctrl_if
    import mix_pkg::*;
#(
    parameter int unsigned ADDR_W = MIX_ADDR_W
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    pix_t              pix1_in;
    pix_t              pix2_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pix_t              wr_data;
    logic              wr_ready;

    modport master (
        input  start,
        input  pix1_in,
        input  pix2_in,
        input  wr_ready,
        output busy,
        output done,
        output rd_en,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output start,
        output pix1_in,
        output pix2_in,
        output wr_ready,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/MixColor.sv
// MixColor: combinational 24-bit colour mixer, per-channel bitwise XOR.
//   a, b - input pixels
//   y    - mixed pixel
module MixColor
    import mix_pkg::*;
(
    input  pix_t a,
    input  pix_t b,
    output pix_t y
);

    rgb_t ca;
    rgb_t cb;
    rgb_t cy;

    assign ca = a;
    assign cb = b;

    // Channel-wise mix; identical to a full-word XOR but keeps the RGB view explicit.
    always_comb begin
        cy   = '0;
        cy.r = ca.r ^ cb.r;
        cy.g = ca.g ^ cb.g;
        cy.b = ca.b ^ cb.b;
    end

    assign y = cy;

endmodule

// File: rtl/mix_ctrl.sv
// mix_ctrl: frame mixer controller. For each pixel of a frame it reads both
// source memories, XOR-mixes the pair and writes the result, honouring
// backpressure on the result write.
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active high
//   bus  - mix_ctrl_if master modport (start/busy/done, source read,
//          result write)
// rd_en, wr_en, busy and done are decoded from state; rd_addr, wr_addr and
// wr_data come straight from flops.
module mix_ctrl
    import mix_pkg::*;
#(
    parameter int unsigned PIX_NUM = MIX_PIX_NUM,
    parameter int unsigned ADDR_W  = MIX_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    mix_ctrl_if.master    bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIX_NUM - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    pix_t              wr_data_q;
    pix_t              wr_data_d;
    pix_t              mix_pix;

    // Pixel mixer
    MixColor u_mix (
        .a (bus.pix1_in),
        .b (bus.pix2_in),
        .y (mix_pix)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state, datapath update and strobe decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.done  = 1'b0;
        bus.busy  = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RD;
                    cnt_d   = '0;
                end
            end
            ST_RD: begin
                bus.rd_en = 1'b1;
                state_d   = ST_WAIT;
            end
            // Source data arrives this cycle; capture the mixed pixel.
            ST_WAIT: begin
                wr_data_d = mix_pix;
                wr_addr_d = cnt_q;
                state_d   = ST_WR;
            end
            // Result held in wr_*_q until the memory accepts it.
            ST_WR: begin
                bus.wr_en = 1'b1;
                if (bus.wr_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_addr = cnt_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_mix_ctrl.sv
// tb_mix_ctrl: self-checking bench for mix_ctrl with a 4-pixel frame on a
// 2-bit address (frame fills the whole address space).
module tb_mix_ctrl;
    import mix_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;

    logic clk = 1'b0;
    logic rst;

    mix_ctrl_if #(.ADDR_W(AW)) bus ();

    mix_ctrl #(.PIX_NUM(N), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source images and reference state
    pix_t src1 [N];
    pix_t src2 [N];
    int   exp_rd     = 0;
    int   exp_wr     = 0;
    int   wr_cnt     = 0;
    int   done_cnt   = 0;
    int   done_cyc   = 0;
    int   done_q [$];
    bit   rnd_mode   = 1'b0;
    int   stall_left = 0;
    int   stall_addr = 0;
    logic prev_stall = 1'b0;
    logic prev_done  = 1'b0;
    logic [AW-1:0] prev_addr;
    pix_t          prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source memories: registered read, data valid the cycle after rd_en
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.pix1_in <= src1[bus.rd_addr];
            bus.pix2_in <= src2[bus.rd_addr];
        end
    end

    // Result memory, write-ready policy and protocol monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_rd       = 0;
            exp_wr       = 0;
            prev_stall   = 1'b0;
            prev_done    = 1'b0;
            bus.wr_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                check("hold_wr_en", bus.wr_en, 1);
                check("hold_wr_addr", bus.wr_addr, prev_addr);
                check("hold_wr_data", bus.wr_data, prev_data);
                check("stall_no_rd", bus.rd_en, 0);
            end
            if (bus.rd_en) begin
                check("rd_addr", bus.rd_addr, exp_rd);
                exp_rd = (exp_rd + 1) % N;
            end
            if (rnd_mode)
                bus.wr_ready = ($urandom_range(0, 2) != 0);
            else if (stall_left > 0 && bus.wr_en && bus.wr_addr == AW'(stall_addr)) begin
                bus.wr_ready = 1'b0;
                stall_left--;
            end else
                bus.wr_ready = 1'b1;
            if (bus.wr_en && bus.wr_ready) begin
                check("wr_addr", bus.wr_addr, exp_wr);
                check("wr_data", bus.wr_data, src1[exp_wr] ^ src2[exp_wr]);
                exp_wr = (exp_wr + 1) % N;
                wr_cnt++;
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
            if (bus.done) begin
                check("done_width", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
                done_q.push_back(cyc);
            end
            prev_done = bus.done;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
    endtask

    // One frame: pulse start, optionally re-pulse while busy, expect one done.
    task automatic run_frame(input string tag, input int exp_lat, input int pulse_at);
        int s;
        int d0;
        int w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        @(posedge clk); #1 bus.start = 1'b1;
        s = cyc + 1;
        @(posedge clk); #1 bus.start = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
        check({tag, "_done_seen"}, done_cnt != d0, 1);
        if (exp_lat > 0) check({tag, "_latency"}, done_cyc - s + 1, exp_lat);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_writes"}, wr_cnt - w0, N);
        check({tag, "_dones"}, done_cnt - d0, 1);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int d0;
        bit found;
        rst       = 1'b1;
        bus.start = 1'b0;
        src1[0] = 24'hFF0000; src2[0] = 24'h00FF00;
        src1[1] = 24'h00FF00; src2[1] = 24'h00FF00;
        src1[2] = 24'h0000FF; src2[2] = 24'hFFFFFF;
        src1[3] = 24'h123456; src2[3] = 24'h654321;

        #3 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("post_reset");

        // Directed image pair, no backpressure; last write hits top address
        run_frame("basic", 3 * N + 1, 0);
        check("basic_wrdata_last", bus.wr_data, 24'h777777);
        check("basic_wraddr_last", bus.wr_addr, N - 1);

        // Five stall cycles on pixel 1
        stall_addr = 1;
        stall_left = 5;
        run_frame("stall", 3 * N + 1 + 5, 0);
        check("stall_consumed", stall_left, 0);

        // Start re-pulsed mid-frame is ignored
        run_frame("restart_ignored", 3 * N + 1, 4);

        // Asynchronous reset while pixel 2 is stalled in write
        stall_addr = 2;
        stall_left = 1000;
        d0 = done_cnt;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr == AW'(2)) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_wr2", found, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1 check_zero("async_rst");
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", done_cnt - d0, 0);
        stall_left = 0;
        rst = 1'b0;
        run_frame("after_abort", 3 * N + 1, 0);

        // Start held high: back-to-back frames
        begin
            int s;
            int k0;
            d0 = done_cnt;
            k0 = done_q.size();
            @(posedge clk); #1 bus.start = 1'b1;
            s = cyc + 1;
            for (int i = 0; i < 300 && done_cnt < d0 + 3; i++) @(posedge clk);
            #1 bus.start = 1'b0;
            check("b2b_three_done", done_cnt - d0, 3);
            if (done_q.size() >= k0 + 3) begin
                check("b2b_first_lat", done_q[k0] - s + 1, 3 * N + 1);
                check("b2b_space1", done_q[k0+1] - done_q[k0], 3 * N + 2);
                check("b2b_space2", done_q[k0+2] - done_q[k0+1], 3 * N + 2);
            end
            repeat (10) @(posedge clk);
            #1 check("b2b_stop_done", done_cnt - d0, 3);
            check("b2b_idle", bus.busy, 0);
        end

        // Random images with random write backpressure
        rnd_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < N; p++) begin
                src1[p] = pix_t'($urandom);
                src2[p] = pix_t'($urandom);
            end
            run_frame("random", 0, 0);
        end
        rnd_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
